// File: rtl/rca_wb_sequencer.sv
// rca_wb_sequencer: buffers RCA result bundles in a small FIFO and serialises
// each bundle into single-register writeback beats (ascending port index).
// A bundle with no enabled ports is reported as one completion-only beat.
// Optional build macro: RCA_WB_X0_FILTER_EN -- when defined, ports whose
// destination register is x0 are dropped from the mask at push time.
module rca_wb_sequencer #(
  parameter int NUM_WRITE_PORTS = 5,
  parameter int XLEN            = 32,
  parameter int ID_W            = 3,
  parameter int DEPTH           = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rca_done,
  input  logic [ID_W-1:0]                 rca_id,
  input  logic [NUM_WRITE_PORTS*XLEN-1:0] rca_rd,
  input  logic [NUM_WRITE_PORTS*5-1:0]    rca_dest_addrs,
  input  logic [NUM_WRITE_PORTS-1:0]      rca_dest_mask,
  output logic                            rca_ready,
  output logic                            wb_valid,
  output logic                            wb_we,
  output logic [4:0]                      wb_addr,
  output logic [XLEN-1:0]                 wb_data,
  output logic [ID_W-1:0]                 wb_id,
  output logic                            wb_last,
  input  logic                            wb_ack,
  output logic                            overflow_err
);

  localparam int NWP   = NUM_WRITE_PORTS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (NWP > 1) ? $clog2(NWP) : 1;

  localparam logic [NWP-1:0]   MASK_ONE = NWP'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t state_q, state_d;

  // FIFO storage (one entry per bundle) and bookkeeping
  logic [ID_W-1:0]     id_mem_q   [DEPTH];
  logic [ID_W-1:0]     id_mem_d   [DEPTH];
  logic [NWP*XLEN-1:0] rd_mem_q   [DEPTH];
  logic [NWP*XLEN-1:0] rd_mem_d   [DEPTH];
  logic [NWP*5-1:0]    addr_mem_q [DEPTH];
  logic [NWP*5-1:0]    addr_mem_d [DEPTH];
  logic [NWP-1:0]      mask_mem_q [DEPTH];
  logic [NWP-1:0]      mask_mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NWP-1:0]      rem_mask_q, rem_mask_d;
  logic                overflow_q, overflow_d;

  logic [NWP-1:0]   push_mask_s;
  logic             push_s;
  logic             ack_s;
  logic             last_s;
  logic             pop_s;
  logic [IDX_W-1:0] idx_s;
  logic [PTR_W-1:0] next_rd_ptr_s;

  assign rca_ready     = (count_q < CNT_FULL);
  assign push_s        = rca_done & rca_ready;
  assign ack_s         = (state_q == DRAIN) & wb_ack;
  assign last_s        = ((rem_mask_q & (rem_mask_q - MASK_ONE)) == '0);
  assign pop_s         = ack_s & last_s;
  assign next_rd_ptr_s = rd_ptr_q + PTR_ONE;
  assign overflow_err  = overflow_q;

  // Effective write mask of the incoming bundle
  always_comb begin
    push_mask_s = rca_dest_mask;
`ifdef RCA_WB_X0_FILTER_EN
    for (int i = 0; i < NWP; i++) begin
      push_mask_s[i] = rca_dest_mask[i] & (rca_dest_addrs[i*5 +: 5] != 5'd0);
    end
`endif
  end

  // Lowest remaining port of the current bundle is the beat on offer
  always_comb begin
    idx_s = '0;
    for (int i = NWP - 1; i >= 0; i--) begin
      if (rem_mask_q[i]) begin
        idx_s = IDX_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  // FIFO, pointer, count, beat-mask and sticky error next-state logic
  always_comb begin
    id_mem_d   = id_mem_q;
    rd_mem_d   = rd_mem_q;
    addr_mem_d = addr_mem_q;
    mask_mem_d = mask_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rem_mask_d = rem_mask_q;
    overflow_d = overflow_q | (rca_done & ~rca_ready);

    if (push_s) begin
      id_mem_d[wr_ptr_q]   = rca_id;
      rd_mem_d[wr_ptr_q]   = rca_rd;
      addr_mem_d[wr_ptr_q] = rca_dest_addrs;
      mask_mem_d[wr_ptr_q] = push_mask_s;
      wr_ptr_d             = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = next_rd_ptr_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // In IDLE the FIFO is empty, so a push becomes the head directly. When the
    // last beat retires with a single entry left, the next head (if any) is
    // the bundle being pushed this very cycle, so bypass it.
    if (state_q == IDLE) begin
      rem_mask_d = push_mask_s;
    end else if (ack_s) begin
      if (last_s) begin
        rem_mask_d = (count_q == CNT_ONE) ? push_mask_s : mask_mem_q[next_rd_ptr_s];
      end else begin
        rem_mask_d = rem_mask_q & (rem_mask_q - MASK_ONE);
      end
    end else begin
      rem_mask_d = rem_mask_q;
    end
  end

  // Datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_mem_q[i]   <= '0;
        rd_mem_q[i]   <= '0;
        addr_mem_q[i] <= '0;
        mask_mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rem_mask_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      id_mem_q   <= id_mem_d;
      rd_mem_q   <= rd_mem_d;
      addr_mem_q <= addr_mem_d;
      mask_mem_q <= mask_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rem_mask_q <= rem_mask_d;
      overflow_q <= overflow_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start draining on push, stop once the FIFO runs dry
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (push_s) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (pop_s && (count_d == '0)) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: beat payload taken from the FIFO head, all zero when idle
  always_comb begin
    wb_valid = 1'b0;
    wb_we    = 1'b0;
    wb_addr  = 5'd0;
    wb_data  = '0;
    wb_id    = '0;
    wb_last  = 1'b0;
    case (state_q)
      DRAIN: begin
        wb_valid = 1'b1;
        wb_id    = id_mem_q[rd_ptr_q];
        wb_last  = last_s;
        if (rem_mask_q != '0) begin
          wb_we   = 1'b1;
          wb_addr = addr_mem_q[rd_ptr_q][int'(idx_s)*5 +: 5];
          wb_data = rd_mem_q[rd_ptr_q][int'(idx_s)*XLEN +: XLEN];
        end else begin
          wb_we = 1'b0;
        end
      end
      default: begin
        wb_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rca_wb_sequencer.sv
// Self-checking bench for rca_wb_sequencer: expected beats are queued when a
// bundle is accepted and compared against every presented beat.
module tb_rca_wb_sequencer;

  localparam int NWP   = 5;
  localparam int XLEN  = 32;
  localparam int ID_W  = 3;
  localparam int DEPTH = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                rca_done;
  logic [ID_W-1:0]     rca_id;
  logic [NWP*XLEN-1:0] rca_rd;
  logic [NWP*5-1:0]    rca_dest_addrs;
  logic [NWP-1:0]      rca_dest_mask;
  logic                rca_ready;
  logic                wb_valid;
  logic                wb_we;
  logic [4:0]          wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic [ID_W-1:0]     wb_id;
  logic                wb_last;
  logic                wb_ack;
  logic                overflow_err;

  rca_wb_sequencer #(
    .NUM_WRITE_PORTS(NWP), .XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rca_done(rca_done), .rca_id(rca_id), .rca_rd(rca_rd),
    .rca_dest_addrs(rca_dest_addrs), .rca_dest_mask(rca_dest_mask),
    .rca_ready(rca_ready), .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_id(wb_id), .wb_last(wb_last), .wb_ack(wb_ack),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
    logic [ID_W-1:0] id;
    logic            last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;
  int    count_m  = 0;
  bit    ovf_m    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NWP*XLEN-1:0] mk_rd(input logic [XLEN-1:0] base);
    logic [NWP*XLEN-1:0] r;
    for (int i = 0; i < NWP; i++) r[i*XLEN +: XLEN] = base + XLEN'(i);
    return r;
  endfunction

  // Reference: expand an accepted bundle into its expected beats
  task automatic push_expected(input logic [ID_W-1:0] id, input logic [NWP*XLEN-1:0] rd,
                               input logic [NWP*5-1:0] addrs, input logic [NWP-1:0] mask);
    logic [NWP-1:0] eff;
    beat_t          b;
    eff = mask;
`ifdef RCA_WB_X0_FILTER_EN
    for (int i = 0; i < NWP; i++) if (addrs[i*5 +: 5] == 5'd0) eff[i] = 1'b0;
`endif
    if (eff == '0) begin
      b = '{we: 1'b0, addr: 5'd0, data: '0, id: id, last: 1'b1};
      exp_q.push_back(b);
    end else begin
      for (int i = 0; i < NWP; i++) begin
        if (eff[i]) begin
          b.we   = 1'b1;
          b.addr = addrs[i*5 +: 5];
          b.data = rd[i*XLEN +: XLEN];
          b.id   = id;
          b.last = ((eff >> (i + 1)) == '0);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // One clock: inputs already set after the falling edge; sample mid-low-phase
  task automatic cycle();
    beat_t got;
    beat_t e;
    bit    pop;
    #3;
    check("wb_valid", 64'(wb_valid), 64'(exp_q.size() != 0));
    check("rca_ready", 64'(rca_ready), 64'(count_m < DEPTH));
    check("overflow_err", 64'(overflow_err), 64'(ovf_m));
    pop = 1'b0;
    if (wb_valid && exp_q.size() != 0) begin
      e   = exp_q[0];
      got = '{we: wb_we, addr: wb_addr, data: wb_data, id: wb_id, last: wb_last};
      if (!e.we) begin
        got.addr = 5'd0;
        got.data = '0;
      end
      check("beat", 64'(got), 64'(e));
      if (wb_ack) begin
        pop = e.last;
        exp_q.delete(0);
      end
    end
    if (rca_done) begin
      if (count_m < DEPTH) begin
        push_expected(rca_id, rca_rd, rca_dest_addrs, rca_dest_mask);
        count_m++;
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (pop) count_m--;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit done, input logic [ID_W-1:0] id, input logic [NWP-1:0] mask,
                       input logic [NWP*5-1:0] addrs, input logic [NWP*XLEN-1:0] rd,
                       input bit ack);
    rca_done       = done;
    rca_id         = id;
    rca_dest_mask  = mask;
    rca_dest_addrs = addrs;
    rca_rd         = rd;
    wb_ack         = ack;
    cycle();
  endtask

  logic [NWP*5-1:0]    addrs_a;
  logic [NWP*XLEN-1:0] rd_a;

  initial begin
    rst = 1'b1;
    rca_done = 1'b0; rca_id = '0; rca_rd = '0; rca_dest_addrs = '0; rca_dest_mask = '0;
    wb_ack = 1'b0;
    addrs_a = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3};
    rd_a    = mk_rd(32'h0000_000A);
    #1;
    check("rst_valid", 64'(wb_valid), 64'd0);
    check("rst_ready", 64'(rca_ready), 64'd1);
    check("rst_ovf", 64'(overflow_err), 64'd0);
    check("rst_payload", 64'({wb_we, wb_last, wb_addr, wb_data, wb_id}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);

    // Sparse mask: beats for ports 0, 2, 4 the cycle after push
    drive(1'b1, 3'd2, 5'b10101, addrs_a, rd_a, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);

    // Completion-only bundle
    drive(1'b1, 3'd1, 5'b00000, addrs_a, rd_a, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);

    // Fill with consumer stalled: third bundle dropped, overflow sticks
    drive(1'b1, 3'd4, 5'b00110, addrs_a, mk_rd(32'h100), 1'b0);
    drive(1'b1, 3'd5, 5'b10000, addrs_a, mk_rd(32'h200), 1'b0);
    drive(1'b1, 3'd6, 5'b11111, addrs_a, mk_rd(32'h300), 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);

    // Mid-bundle stall of four cycles
    drive(1'b1, 3'd7, 5'b01011, addrs_a, mk_rd(32'h400), 1'b1);
    drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);

    // Push alongside last-beat ack: refused when full, accepted at count 1
    drive(1'b1, 3'd1, 5'b00001, addrs_a, mk_rd(32'h500), 1'b0);
    drive(1'b1, 3'd2, 5'b00001, addrs_a, mk_rd(32'h600), 1'b0);
    drive(1'b1, 3'd3, 5'b00001, addrs_a, mk_rd(32'h700), 1'b1);
    drive(1'b1, 3'd4, 5'b00010, addrs_a, mk_rd(32'h800), 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);

    // Reset during the second beat of a bundle
    drive(1'b1, 3'd5, 5'b00111, addrs_a, mk_rd(32'h900), 1'b1);
    drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", 64'(wb_valid), 64'd0);
    check("rst_mid_ovf", 64'(overflow_err), 64'd0);
    check("rst_mid_ready", 64'(rca_ready), 64'd1);
    check("rst_mid_payload", 64'({wb_we, wb_last, wb_addr, wb_data, wb_id}), 64'd0);
    exp_q.delete();
    count_m = 0;
    ovf_m   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);

    // Destination x0 on port 0, x9 on port 1
    drive(1'b1, 3'd3, 5'b00011, {5'd0, 5'd0, 5'd0, 5'd9, 5'd0}, mk_rd(32'hA00), 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);

    // Random traffic with occasional x0 destinations and backpressure
    for (int n = 0; n < 300; n++) begin
      logic [NWP*5-1:0] ra;
      for (int p = 0; p < NWP; p++) ra[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      drive($urandom_range(0, 2) == 0, ID_W'($urandom), NWP'($urandom), ra,
            mk_rd($urandom), $urandom_range(0, 3) != 0);
    end
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
      drive(1'b0, 3'd0, 5'b00000, addrs_a, rd_a, 1'b1);
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
